// File: rtl/stripes_pkg.sv
// stripes_pkg
//   Shared types and constants for the Stripes bit-serial weight feeder.
//   ser_state_t : serializer state encoding
//   COL_IDX_W   : width of the bit-position index (limits DATA_WIDTH to 8)
//   vec_t       : default-sized lane vector (16 lanes x 8 bits)
package stripes_pkg;

  localparam int COL_IDX_W        = 3;
  localparam int PKG_VEC_LENGTH   = 16;
  localparam int PKG_DATA_WIDTH   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2
  } ser_state_t;

  typedef logic [PKG_VEC_LENGTH-1:0][PKG_DATA_WIDTH-1:0] vec_t;

endpackage

// File: rtl/stripes_weight_serializer_bit_slicer.sv
// stripes_bit_slicer
//   Lane-wise selection of one weight bit-plane.
//   w_reg    : held weight vector
//   bit_cnt  : bit position to select
//   shift_en : high while serializing; low forces all bits to 0
//   w_bit    : selected bit per lane
module stripes_bit_slicer
  import stripes_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 16
) (
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] w_reg,
  input  logic [COL_IDX_W-1:0]                  bit_cnt,
  input  logic                                  shift_en,
  output logic [VEC_LENGTH-1:0]                 w_bit
);

  always_comb begin
    w_bit = '0;
    if (shift_en) begin
      for (int j = 0; j < VEC_LENGTH; j++) begin
        w_bit[j] = w_reg[j][bit_cnt];
      end
    end
  end

endmodule

// File: rtl/stripes_weight_serializer.sv
// stripes_weight_serializer
//   Bit-serial feeder for the Stripes MAC. Accepts a weight/activation vector
//   pair per handshake, holds the activations and emits the weights one
//   bit-plane per cycle MSB first, then one flush cycle to drain the MAC's
//   two-stage pipeline. Generates load_accum and result_valid for the MAC.
//   Inputs : clk, reset (sync, active-high), in_valid, in_w, in_act,
//            in_acc_first, in_acc_last, stall
//   Outputs: in_ready, act_out, w_bit, column_idx, is_msb, mac_en,
//            load_accum, result_valid, busy
module stripes_weight_serializer
  import stripes_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 16
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic signed [VEC_LENGTH-1:0][DATA_WIDTH-1:0] in_w,
  input  logic signed [VEC_LENGTH-1:0][DATA_WIDTH-1:0] in_act,
  input  logic                                         in_acc_first,
  input  logic                                         in_acc_last,
  input  logic                                         stall,
  output logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]        act_out,
  output logic [VEC_LENGTH-1:0]                        w_bit,
  output logic [COL_IDX_W-1:0]                         column_idx,
  output logic                                         is_msb,
  output logic                                         mac_en,
  output logic                                         load_accum,
  output logic                                         result_valid,
  output logic                                         busy
);

  localparam logic [COL_IDX_W-1:0] BIT_MSB = COL_IDX_W'(DATA_WIDTH - 1);

  ser_state_t                           state, state_next;
  logic [COL_IDX_W-1:0]                 bit_cnt, bit_cnt_next;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] w_reg;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] act_reg;
  logic                                 first_reg, last_reg;
  logic                                 pending_first, pending_last;
  logic                                 accept;
  logic                                 last_bit;

  assign last_bit = (state == SHIFT) && (bit_cnt == '0);

  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    in_ready     = !stall && ((state == IDLE) || (state == FLUSH) || last_bit);
    accept       = in_valid && in_ready;
    if (accept) begin
      state_next   = SHIFT;
      bit_cnt_next = BIT_MSB;
    end else if (!stall) begin
      case (state)
        SHIFT: begin
          if (bit_cnt == '0) state_next = FLUSH;
          else               bit_cnt_next = bit_cnt - 1'b1;
        end
        FLUSH:   state_next = IDLE;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      w_reg         <= '0;
      act_reg       <= '0;
      first_reg     <= 1'b0;
      last_reg      <= 1'b0;
      pending_first <= 1'b0;
      pending_last  <= 1'b0;
      result_valid  <= 1'b0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
      if (accept) begin
        w_reg     <= in_w;
        act_reg   <= in_act;
        first_reg <= in_acc_first;
        last_reg  <= in_acc_last;
      end
      // Flags advance only on MAC-enabled cycles so a stall holds them.
      // first/last are read before any back-to-back accept overwrites them.
      if (mac_en) begin
        pending_first <= is_msb && first_reg;
        pending_last  <= last_bit && last_reg;
      end
      result_valid <= mac_en && pending_last;
    end
  end

  stripes_bit_slicer #(
    .DATA_WIDTH(DATA_WIDTH),
    .VEC_LENGTH(VEC_LENGTH)
  ) u_slicer (
    .w_reg   (w_reg),
    .bit_cnt (bit_cnt),
    .shift_en(state == SHIFT),
    .w_bit   (w_bit)
  );

  assign act_out    = act_reg;
  assign column_idx = (state == SHIFT) ? bit_cnt : '0;
  assign is_msb     = (state == SHIFT) && (bit_cnt == BIT_MSB);
  assign mac_en     = (state != IDLE) && !stall;
  assign load_accum = pending_first && mac_en;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_stripes_weight_serializer.sv
module tb_stripes_weight_serializer;
  import stripes_pkg::*;

  localparam int ACCUM_PREV = 0;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  vec_t        in_w, in_act, act_out;
  logic        in_acc_first, in_acc_last, stall;
  logic [15:0] w_bit;
  logic [2:0]  column_idx;
  logic        is_msb, mac_en, load_accum, result_valid, busy;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  stripes_weight_serializer #(.DATA_WIDTH(8), .VEC_LENGTH(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_w(in_w), .in_act(in_act), .in_acc_first(in_acc_first),
    .in_acc_last(in_acc_last), .stall(stall), .act_out(act_out),
    .w_bit(w_bit), .column_idx(column_idx), .is_msb(is_msb),
    .mac_en(mac_en), .load_accum(load_accum), .result_valid(result_valid),
    .busy(busy)
  );

  // Behavioural model of the external two-stage Stripes MAC.
  int psum_reg, accum;

  function automatic int calc_psum();
    int s = 0;
    for (int j = 0; j < 16; j++)
      if (w_bit[j]) s += int'($signed(act_out[j]));
    s = s * (1 << column_idx);
    if (is_msb) s = -s;
    return s;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      psum_reg <= 0;
      accum    <= 0;
    end else if (mac_en) begin
      psum_reg <= calc_psum();
      accum    <= (load_accum ? ACCUM_PREV : accum) + psum_reg;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t fill(input logic [7:0] v);
    vec_t r;
    for (int j = 0; j < 16; j++) r[j] = v;
    return r;
  endfunction

  // Presents a vector in cycle 0 and returns at the start of cycle 1.
  task automatic send_vec(input logic [7:0] w, input logic [7:0] a,
                          input logic first, input logic last);
    in_w = fill(w); in_act = fill(a);
    in_acc_first = first; in_acc_last = last;
    in_valid = 1'b1;
    next_cycle();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; stall = 1'b0;
    in_w = '0; in_act = '0; in_acc_first = 1'b0; in_acc_last = 1'b0;
    next_cycle(); next_cycle();
    reset = 1'b0;
    next_cycle();
    checks++; if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy); else passes++;
    checks++; if (mac_en !== 1'b0) $display("FAIL reset mac_en: got %b want 0", mac_en); else passes++;
    checks++; if (act_out !== '0) $display("FAIL reset act_out: got %h want 0", act_out); else passes++;
    checks++; if ({w_bit, column_idx, is_msb} !== '0) $display("FAIL reset bits: got %h/%0d/%b want 0", w_bit, column_idx, is_msb); else passes++;
    checks++; if ({load_accum, result_valid} !== 2'b00) $display("FAIL reset flags: got %b%b want 00", load_accum, result_valid); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset in_ready: got %b want 1", in_ready); else passes++;
  endtask

  task automatic test_single();
    logic [2:0] ec;
    send_vec(8'h01, 8'd3, 1'b1, 1'b1);
    for (int c = 1; c <= 12; c++) begin
      ec = (c <= 8) ? 3'(8 - c) : 3'd0;
      checks++; if (column_idx !== ec) $display("FAIL single col c%0d: got %0d want %0d", c, column_idx, ec); else passes++;
      checks++; if (is_msb !== (c == 1)) $display("FAIL single is_msb c%0d: got %b", c, is_msb); else passes++;
      checks++; if (mac_en !== (c <= 9)) $display("FAIL single mac_en c%0d: got %b", c, mac_en); else passes++;
      checks++; if (busy !== (c <= 9)) $display("FAIL single busy c%0d: got %b", c, busy); else passes++;
      checks++; if (in_ready !== (c >= 8)) $display("FAIL single in_ready c%0d: got %b", c, in_ready); else passes++;
      checks++; if (load_accum !== (c == 2)) $display("FAIL single load_accum c%0d: got %b", c, load_accum); else passes++;
      checks++; if (result_valid !== (c == 10)) $display("FAIL single result_valid c%0d: got %b", c, result_valid); else passes++;
      checks++; if (w_bit !== ((c == 8) ? 16'hFFFF : 16'h0000)) $display("FAIL single w_bit c%0d: got %h", c, w_bit); else passes++;
      if (c == 10) begin
        checks++; if (accum !== 48) $display("FAIL single accum: got %0d want 48", accum); else passes++;
      end
      next_cycle();
    end
  endtask

  task automatic test_negative();
    send_vec(8'hFF, 8'd1, 1'b1, 1'b1);
    for (int c = 1; c <= 11; c++) begin
      if (c <= 8) begin
        checks++; if (w_bit !== 16'hFFFF) $display("FAIL neg w_bit c%0d: got %h want ffff", c, w_bit); else passes++;
      end
      checks++; if (result_valid !== (c == 10)) $display("FAIL neg result_valid c%0d: got %b", c, result_valid); else passes++;
      if (c == 10) begin
        checks++; if (accum !== -16) $display("FAIL neg accum: got %0d want -16", accum); else passes++;
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ec;
    in_w = fill(8'h01); in_act = fill(8'd3);
    in_acc_first = 1'b1; in_acc_last = 1'b1; in_valid = 1'b1;
    next_cycle();
    in_w = fill(8'h02); in_act = fill(8'd1);
    for (int c = 1; c <= 19; c++) begin
      if (c == 9) in_valid = 1'b0;
      ec = (c <= 8) ? 3'(8 - c) : (c <= 16) ? 3'(16 - c) : 3'd0;
      if (c <= 8) begin
        checks++; if (in_ready !== (c == 8)) $display("FAIL b2b in_ready c%0d: got %b", c, in_ready); else passes++;
      end
      checks++; if (column_idx !== ec) $display("FAIL b2b col c%0d: got %0d want %0d", c, column_idx, ec); else passes++;
      checks++; if (is_msb !== (c == 1 || c == 9)) $display("FAIL b2b is_msb c%0d: got %b", c, is_msb); else passes++;
      checks++; if (mac_en !== (c <= 17)) $display("FAIL b2b mac_en c%0d: got %b", c, mac_en); else passes++;
      checks++; if (load_accum !== (c == 2 || c == 10)) $display("FAIL b2b load_accum c%0d: got %b", c, load_accum); else passes++;
      checks++; if (result_valid !== (c == 10 || c == 18)) $display("FAIL b2b result_valid c%0d: got %b", c, result_valid); else passes++;
      if (c == 8) begin
        checks++; if (act_out !== fill(8'd3)) $display("FAIL b2b act_out c8: got %h", act_out); else passes++;
      end
      if (c == 9) begin
        checks++; if (act_out !== fill(8'd1)) $display("FAIL b2b act_out c9: got %h", act_out); else passes++;
      end
      if (c == 10) begin
        checks++; if (accum !== 48) $display("FAIL b2b accum A: got %0d want 48", accum); else passes++;
      end
      if (c == 18) begin
        checks++; if (accum !== 32) $display("FAIL b2b accum B: got %0d want 32", accum); else passes++;
      end
      next_cycle();
    end
  endtask

  task automatic test_stall();
    logic [2:0] ec;
    send_vec(8'h01, 8'd3, 1'b1, 1'b1);
    for (int c = 1; c <= 14; c++) begin
      if (c == 4) stall = 1'b1;
      if (c == 7) stall = 1'b0;
      #1;
      ec = (c <= 3) ? 3'(8 - c) : (c <= 6) ? 3'd4 : (c <= 11) ? 3'(11 - c) : 3'd0;
      checks++; if (column_idx !== ec) $display("FAIL stall col c%0d: got %0d want %0d", c, column_idx, ec); else passes++;
      checks++; if (mac_en !== (c <= 3 || (c >= 7 && c <= 12))) $display("FAIL stall mac_en c%0d: got %b", c, mac_en); else passes++;
      checks++; if (result_valid !== (c == 13)) $display("FAIL stall result_valid c%0d: got %b", c, result_valid); else passes++;
      if (c >= 4 && c <= 6) begin
        checks++; if (in_ready !== 1'b0) $display("FAIL stall in_ready c%0d: got %b want 0", c, in_ready); else passes++;
        checks++; if (busy !== 1'b1) $display("FAIL stall busy c%0d: got %b want 1", c, busy); else passes++;
      end
      if (c == 13) begin
        checks++; if (accum !== 48) $display("FAIL stall accum: got %0d want 48", accum); else passes++;
      end
      next_cycle();
    end
  endtask

  task automatic test_accumulate();
    int pulses = 0;
    int pulse_cycle = -1;
    int pulse_accum = 0;
    in_w = fill(8'h01); in_act = fill(8'd2);
    in_acc_first = 1'b1; in_acc_last = 1'b0; in_valid = 1'b1;
    next_cycle();
    in_act = fill(8'd5); in_acc_first = 1'b0; in_acc_last = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      if (c == 9) in_valid = 1'b0;
      if (result_valid === 1'b1) begin
        pulses++;
        pulse_cycle = c;
        pulse_accum = accum;
      end
      next_cycle();
    end
    checks++; if (pulses !== 1) $display("FAIL acc pulses: got %0d want 1", pulses); else passes++;
    checks++; if (pulse_cycle !== 18) $display("FAIL acc pulse cycle: got %0d want 18", pulse_cycle); else passes++;
    checks++; if (pulse_accum !== 112) $display("FAIL acc accum: got %0d want 112", pulse_accum); else passes++;
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    send_vec(8'h01, 8'd3, 1'b1, 1'b1);
    for (int c = 1; c <= 4; c++) next_cycle();
    reset = 1'b1;
    next_cycle();
    checks++; if (busy !== 1'b0) $display("FAIL rstmid busy: got %b want 0", busy); else passes++;
    checks++; if ({mac_en, load_accum, result_valid, is_msb} !== 4'b0000) $display("FAIL rstmid ctrl: got %b%b%b%b want 0000", mac_en, load_accum, result_valid, is_msb); else passes++;
    checks++; if ({w_bit, column_idx} !== '0) $display("FAIL rstmid bits: got %h/%0d want 0", w_bit, column_idx); else passes++;
    checks++; if (act_out !== '0) $display("FAIL rstmid act_out: got %h want 0", act_out); else passes++;
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (result_valid === 1'b1) pulses++;
      next_cycle();
    end
    checks++; if (pulses !== 0) $display("FAIL rstmid stray result_valid: got %0d want 0", pulses); else passes++;
    send_vec(8'h01, 8'd4, 1'b1, 1'b1);
    for (int c = 1; c <= 11; c++) begin
      checks++; if (result_valid !== (c == 10)) $display("FAIL rstmid fresh result_valid c%0d: got %b", c, result_valid); else passes++;
      if (c == 10) begin
        checks++; if (accum !== 64) $display("FAIL rstmid fresh accum: got %0d want 64", accum); else passes++;
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_negative();
    test_back_to_back();
    test_stall();
    test_accumulate();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
